// File: rtl/demux_1ton_stream_if.sv
// Bundle for the 1-to-N stream demultiplexer: one producer stream in, N consumer streams out,
// plus drop reporting and a per-slot state view.
interface demux_1ton_stream_if #(
    parameter int N_OUT  = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
);
    // Handshake: a beat moves on a rising edge exactly when valid and ready are both 1 in the
    // cycle before it; ready never looks at valid, and a held beat is never withdrawn.
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       data;
    logic [SEL_W-1:0]        sel;
    logic                    bcast;
    logic [N_OUT*DATA_W-1:0] y_data;
    logic [N_OUT-1:0]        y_valid;
    logic [N_OUT-1:0]        y_ready;
    logic                    err_sel;
    logic [7:0]              drop_cnt;
    logic [N_OUT-1:0]        slot_state;

    modport master (
        output in_valid, data, sel, bcast, y_ready,
        input  in_ready, y_data, y_valid, err_sel, drop_cnt, slot_state
    );

    modport slave (
        input  in_valid, data, sel, bcast, y_ready,
        output in_ready, y_data, y_valid, err_sel, drop_cnt, slot_state
    );
endinterface

// File: rtl/demux_1ton_stream.sv
// Registered 1-to-N stream demultiplexer: one holding slot per channel, backpressure,
// broadcast to every channel, and counting of beats addressed to a channel that does not exist.
module demux_1ton_stream #(
    parameter int N_OUT  = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_1ton_stream_if.slave   bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t                   slot_q [N_OUT];
    logic [N_OUT*DATA_W-1:0] y_data_q;
    logic                    err_q;
    logic [7:0]              drop_q;

    logic [N_OUT-1:0] full;
    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] sel_hot;
    logic [N_OUT-1:0] load;
    logic             sel_ok;
    logic             ready;
    logic             accept;
    logic             drop;

    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            full[i]    = (slot_q[i] == FULL);
            sel_hot[i] = (bus.sel == SEL_W'(i));
        end
    end

    // A slot can take a beat when it is empty or is being drained on this same edge.
    assign free   = ~full | bus.y_ready;
    assign sel_ok = |sel_hot;

    // An out-of-range select is always accepted so the producer never deadlocks on it.
    always_comb begin
        ready = 1'b1;
        if (bus.bcast)
            ready = &free;
        else if (sel_ok)
            ready = |(sel_hot & free);
    end

    assign accept = bus.in_valid & ready;
    assign drop   = accept & ~bus.bcast & ~sel_ok;

    always_comb begin
        load = '0;
        if (accept)
            load = bus.bcast ? {N_OUT{1'b1}} : sel_hot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++)
                slot_q[i] <= EMPTY;
            y_data_q <= '0;
            err_q    <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                // Load wins over drain so a simultaneous drain+load leaves the slot full.
                if (load[i]) begin
                    slot_q[i]                      <= FULL;
                    y_data_q[i*DATA_W +: DATA_W]   <= bus.data;
                end else if (full[i] && bus.y_ready[i]) begin
                    slot_q[i] <= EMPTY;
                end
            end
            err_q <= drop;
            if (drop && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.y_valid    = full;
    assign bus.y_data     = y_data_q;
    assign bus.err_sel    = err_q;
    assign bus.drop_cnt   = drop_q;
    assign bus.slot_state = full;
endmodule

// File: tb/tb_demux_1ton_stream.sv
// Bench for demux_1ton_stream with six channels, so select values 6 and 7 are out of range.
module tb_demux_1ton_stream;
    localparam int N = 6;
    localparam int W = 8;
    localparam int S = 3;

    logic clk;
    logic rst_n;

    demux_1ton_stream_if #(.N_OUT(N), .DATA_W(W), .SEL_W(S)) bus ();

    demux_1ton_stream #(.N_OUT(N), .DATA_W(W), .SEL_W(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: each channel is a queue of beats it still owes its consumer.
    logic [W-1:0] exp_q [N][$];
    logic [W-1:0] last_data [N];
    int           drops_exp;
    logic         err_exp;
    int           checks;
    int           errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int ch = 0; ch < N; ch++) begin
            exp_q[ch].delete();
            last_data[ch] = '0;
        end
        drops_exp = 0;
        err_exp   = 1'b0;
    endtask

    // Evaluated at the falling edge, after the monitor has retired this cycle's drains.
    task automatic model_step();
        logic all_empty;
        logic rdy;
        logic acc;
        logic dropped;
        all_empty = 1'b1;
        for (int ch = 0; ch < N; ch++)
            if (exp_q[ch].size() != 0) all_empty = 1'b0;
        if (bus.bcast)
            rdy = all_empty;
        else if (int'(bus.sel) < N)
            rdy = (exp_q[int'(bus.sel)].size() == 0);
        else
            rdy = 1'b1;
        check("in_ready", 64'(bus.in_ready), 64'(rdy));
        acc     = bus.in_valid & rdy;
        dropped = 1'b0;
        if (acc) begin
            if (bus.bcast) begin
                for (int ch = 0; ch < N; ch++) exp_q[ch].push_back(bus.data);
            end else if (int'(bus.sel) < N) begin
                exp_q[int'(bus.sel)].push_back(bus.data);
            end else begin
                dropped = 1'b1;
            end
        end
        err_exp = dropped;
        if (dropped && drops_exp < 255) drops_exp++;
    endtask

    task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic [S-1:0] s,
                               input logic b, input logic [N-1:0] yr);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.data     = d;
        bus.sel      = s;
        bus.bcast    = b;
        bus.y_ready  = yr;
        @(negedge clk);
        model_step();
    endtask

    task automatic random_cycles(input int n);
        logic [N-1:0] yr;
        for (int k = 0; k < n; k++) begin
            for (int ch = 0; ch < N; ch++) yr[ch] = ($urandom_range(0, 3) != 0);
            drive_cycle(($urandom_range(0, 3) != 0), W'($urandom), S'($urandom_range(0, 7)),
                        ($urandom_range(0, 7) == 0), yr);
        end
    endtask

    // Monitor: runs after outputs settle from the rising edge and this cycle's inputs are applied.
    always begin
        logic [N-1:0]   ev;
        logic [N*W-1:0] ed;
        @(posedge clk);
        #3;
        if (rst_n) begin
            for (int ch = 0; ch < N; ch++) begin
                ev[ch]          = (exp_q[ch].size() != 0);
                ed[ch*W +: W]   = ev[ch] ? exp_q[ch][0] : last_data[ch];
            end
            check("y_valid", 64'(bus.y_valid), 64'(ev));
            check("y_data", 64'(bus.y_data), 64'(ed));
            check("slot_state", 64'(bus.slot_state), 64'(ev));
            check("err_sel", 64'(bus.err_sel), 64'(err_exp));
            check("drop_cnt", 64'(bus.drop_cnt), 64'(drops_exp));
            for (int ch = 0; ch < N; ch++)
                if (ev[ch] && bus.y_ready[ch]) last_data[ch] = exp_q[ch].pop_front();
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.data     = '0;
        bus.sel      = '0;
        bus.bcast    = 1'b0;
        bus.y_ready  = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_y_valid", 64'(bus.y_valid), 64'(0));
        check("rst_y_data", 64'(bus.y_data), 64'(0));
        check("rst_err_sel", 64'(bus.err_sel), 64'(0));
        check("rst_drop_cnt", 64'(bus.drop_cnt), 64'(0));
        rst_n = 1'b1;

        // Single unicast beat with consumers always ready.
        drive_cycle(1'b1, 8'hA5, 3'd5, 1'b0, '1);
        drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);
        drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);

        // Channel 2 stalled: second beat waits, then loads on the edge the first drains.
        drive_cycle(1'b1, 8'h11, 3'd2, 1'b0, 6'b111011);
        drive_cycle(1'b1, 8'h22, 3'd2, 1'b0, 6'b111011);
        drive_cycle(1'b1, 8'h22, 3'd2, 1'b0, 6'b111011);
        drive_cycle(1'b1, 8'h22, 3'd2, 1'b0, '1);
        drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);

        // Broadcast blocked by one held channel, released when it drains.
        drive_cycle(1'b1, 8'h77, 3'd5, 1'b0, 6'b011111);
        drive_cycle(1'b1, 8'h3C, 3'd0, 1'b1, 6'b011111);
        drive_cycle(1'b1, 8'h3C, 3'd0, 1'b1, 6'b011111);
        drive_cycle(1'b1, 8'h3C, 3'd0, 1'b1, '1);
        drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, 6'b000000);
        drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);

        // Out-of-range selects, including while the target-less beat meets a stalled channel.
        drive_cycle(1'b1, 8'h99, 3'd7, 1'b0, '0);
        drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);
        drive_cycle(1'b1, 8'h98, 3'd6, 1'b0, '1);
        drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);

        // Round-robin stream with everyone ready: one accept per cycle.
        for (int k = 0; k < 2 * N; k++)
            drive_cycle(1'b1, W'(8'h40 + k), S'(k % N), 1'b0, '1);
        drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);

        random_cycles(1500);

        // Drop counter saturation.
        for (int k = 0; k < 300; k++)
            drive_cycle(1'b1, W'($urandom), S'($urandom_range(6, 7)), 1'b0, '1);
        drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);
        check("drop_cnt_sat", 64'(bus.drop_cnt), 64'(255));

        // Mid-cycle asynchronous reset with channels 0 and 3 holding stalled beats.
        drive_cycle(1'b1, 8'h0A, 3'd0, 1'b0, 6'b110110);
        drive_cycle(1'b1, 8'h3B, 3'd3, 1'b0, 6'b110110);
        drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, 6'b110110);
        #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("async_rst_y_valid", 64'(bus.y_valid), 64'(0));
        check("async_rst_y_data", 64'(bus.y_data), 64'(0));
        check("async_rst_drop_cnt", 64'(bus.drop_cnt), 64'(0));
        model_clear();
        #1;
        rst_n = 1'b1;

        random_cycles(500);
        drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);
        drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
